// File: rtl/coin_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// coin_pulse_conditioner
//
// Front-end for the vending-machine credit accumulator. Three raw coin-sensor
// levels (1, 2 and 5 rupee chutes) are synchronised and debounced. Each
// debounced 0->1 edge becomes a coin event. Events are queued in a small FIFO
// and leave as registered, single-cycle, at-most-one-hot pulses. The
// accumulator therefore never sees two coins at once. It also never loses a
// coin while it holds accept_en low, unless the queue is full.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a level is accepted
//                    (2..255)
//   FIFO_DEPTH       event queue entries (power of two, >= 2)
//
// Ports
//   clk              clock, rising edge
//   reset            asynchronous, active-high reset
//   coin_raw_1/2/5   raw asynchronous sensor levels, high while a coin passes
//   accept_en        downstream can take a coin this cycle
//   clear_overflow   clears the sticky overflow flag (a same-cycle drop wins)
//   one_rupee        registered one-cycle coin pulse (1 rupee)
//   two_rupees       registered one-cycle coin pulse (2 rupees)
//   five_rupees      registered one-cycle coin pulse (5 rupees)
//   pending          current FIFO occupancy
//   overflow         sticky: at least one event was dropped
//   drop_count       saturating count of dropped events
//                    (only when COIN_DROP_COUNT_EN is defined)
//
// Build option
//   COIN_DROP_COUNT_EN  adds the drop_count port and its 8-bit counter
// -----------------------------------------------------------------------------
module coin_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          coin_raw_1,
    input  logic                          coin_raw_2,
    input  logic                          coin_raw_5,
    input  logic                          accept_en,
    input  logic                          clear_overflow,
    output logic                          one_rupee,
    output logic                          two_rupees,
    output logic                          five_rupees,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          overflow
`ifdef COIN_DROP_COUNT_EN
    ,
    output logic [7:0]                    drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);      // pointer width
    localparam int PW = $clog2(FIFO_DEPTH) + 1;  // occupancy width

    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [7:0]    CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Queue entry encoding. COIN_NONE is never written into the queue. It only
    // fills unused event slots.
    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_1    = 2'd1,
        COIN_2    = 2'd2,
        COIN_5    = 2'd3
    } coin_e;

    // Channel index: 0 = 1 rupee, 1 = 2 rupees, 2 = 5 rupees.
    logic [2:0] w_raw;
    assign w_raw = {coin_raw_5, coin_raw_2, coin_raw_1};

    // -------------------------------------------------------------------------
    // Two-flop synchroniser per channel
    // -------------------------------------------------------------------------
    logic [2:0] r_sync_meta;
    logic [2:0] r_sync;

    // NOTE: clocked state uses non-blocking (<=) assignments only. Every flop
    //       then samples pre-edge values, whatever the order of the processes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= w_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: the stable level follows the synchronised level only after
    // DEBOUNCE_CYCLES consecutive disagreeing edges. Any agreement restarts
    // the count.
    // -------------------------------------------------------------------------
    logic [2:0] r_stable;
    logic [2:0] r_stable_d;
    logic [7:0] r_db_cnt [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            r_db_cnt   <= '{default: 8'd0};
        end else begin
            r_stable_d <= r_stable;
            for (int ch = 0; ch < 3; ch++) begin
                if (r_sync[ch] == r_stable[ch]) begin
                    r_db_cnt[ch] <= 8'd0;
                end else if (r_db_cnt[ch] == CNT_LAST) begin
                    // This is the D-th disagreeing edge, so accept the new level.
                    r_stable[ch] <= r_sync[ch];
                    r_db_cnt[ch] <= 8'd0;
                end else begin
                    r_db_cnt[ch] <= r_db_cnt[ch] + 8'd1;
                end
            end
        end
    end

    // A coin event is one cycle of "stable is high now but was low last
    // cycle". The event is written into the queue on the following edge.
    logic [2:0] w_rise;
    assign w_rise = r_stable & ~r_stable_d;

    // -------------------------------------------------------------------------
    // Event queue
    // -------------------------------------------------------------------------
    coin_e         r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [PW-1:0] r_pending;
    logic          r_one;
    logic          r_two;
    logic          r_five;
    logic          r_overflow;

    // Same-cycle events are packed into consecutive slots in priority order
    // 5, 2, 1. Slot 3 is never filled. It exists so that the running index
    // can never point outside the array.
    coin_e         w_ev_slot [4];
    logic [1:0]    w_ev_num;
    logic          w_pop;
    logic [PW-1:0] w_free;
    logic [1:0]    w_accept;
    logic [1:0]    w_drop;

    // NOTE: every signal driven here gets a default first. No path can leave
    //       a signal unassigned, so no latch is inferred.
    always_comb begin
        w_ev_slot = '{default: COIN_NONE};
        w_ev_num  = 2'd0;
        w_accept  = 2'd0;

        if (w_rise[2]) begin
            w_ev_slot[w_ev_num] = COIN_5;
            w_ev_num            = w_ev_num + 2'd1;
        end
        if (w_rise[1]) begin
            w_ev_slot[w_ev_num] = COIN_2;
            w_ev_num            = w_ev_num + 2'd1;
        end
        if (w_rise[0]) begin
            w_ev_slot[w_ev_num] = COIN_1;
            w_ev_num            = w_ev_num + 2'd1;
        end

        // A pop in the same cycle frees its slot for an incoming event.
        w_pop  = accept_en && (r_pending != '0);
        w_free = DEPTH_P - r_pending + PW'(w_pop);

        // Events beyond the free space fall off the low-priority end of the
        // packed list. When they do, free < 3, so it fits in two bits.
        if (int'(w_ev_num) <= int'(w_free)) begin
            w_accept = w_ev_num;
        end else begin
            w_accept = w_free[1:0];
        end
        w_drop = w_ev_num - w_accept;
    end

    // NOTE: the queue storage is reset together with the rest of the block.
    //       It is only a few bits, and resetting it keeps X out of simulation
    //       after any reset, including one asserted mid-operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem     <= '{default: COIN_NONE};
            r_wr      <= '0;
            r_rd      <= '0;
            r_pending <= '0;
            r_one     <= 1'b0;
            r_two     <= 1'b0;
            r_five    <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(w_accept)) begin
                    r_mem[r_wr + AW'(k)] <= w_ev_slot[k];
                end
            end
            // Pointers wrap naturally because the depth is a power of two.
            r_wr      <= r_wr + AW'(w_accept);
            r_pending <= r_pending + PW'(w_accept) - PW'(w_pop);

            // The pulse comes from the head entry only. There is no bypass,
            // and all outputs are low in any cycle without a pop.
            r_one  <= w_pop && (r_mem[r_rd] == COIN_1);
            r_two  <= w_pop && (r_mem[r_rd] == COIN_2);
            r_five <= w_pop && (r_mem[r_rd] == COIN_5);
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow: a drop in the same cycle beats clear_overflow.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop != 2'd0) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef COIN_DROP_COUNT_EN
    // -------------------------------------------------------------------------
    // Saturating drop counter. It adds 0..3 per cycle, and only reset clears it.
    // -------------------------------------------------------------------------
    logic [7:0] r_drop_count;
    logic [8:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= 8'd0;
        end else if (w_drop_sum[8]) begin
            r_drop_count <= 8'hFF;
        end else begin
            r_drop_count <= w_drop_sum[7:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign one_rupee   = r_one;
    assign two_rupees  = r_two;
    assign five_rupees = r_five;
    assign pending     = r_pending;
    assign overflow    = r_overflow;

endmodule
